// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters (r0, r1) with
//   round-robin arbitration. Every operation moves through three phases:
//   IDLE (accept), EXEC (the ALU settles on the registered operands) and
//   RESP (the response is held until the owning requester takes it).
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   rN_valid / rN_ready      request handshake for requester N (0 or 1)
//   rN_src1, rN_src2, rN_ctrl  operands and ALU_control for requester N
//   rN_rsp_valid / rN_rsp_ready  response handshake for requester N
//   rN_result, rN_zcv        captured result and {zero,cout,overflow} flags
//   alu_rst_n                active-low reset for the ALU instance (~rst)
//   alu_src1/src2/ctrl       registered operands driven into the ALU
//   alu_result, alu_zero, alu_cout, alu_overflow  ALU outputs
//   busy                     high whenever an operation is in flight
//   grant                    requester that currently owns the ALU
module alu_arbiter #(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 4,
  parameter int RR_INIT = 0
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_src1,
  input  logic [DATA_W-1:0] r0_src2,
  input  logic [CTRL_W-1:0] r0_ctrl,
  output logic              r0_rsp_valid,
  input  logic              r0_rsp_ready,
  output logic [DATA_W-1:0] r0_result,
  output logic [2:0]        r0_zcv,

  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_src1,
  input  logic [DATA_W-1:0] r1_src2,
  input  logic [CTRL_W-1:0] r1_ctrl,
  output logic              r1_rsp_valid,
  input  logic              r1_rsp_ready,
  output logic [DATA_W-1:0] r1_result,
  output logic [2:0]        r1_zcv,

  output logic              alu_rst_n,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_cout,
  input  logic              alu_overflow,

  output logic              busy,
  output logic              grant
);

  localparam logic RR_INIT_BIT = 1'(RR_INIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   prio_reg, prio_next;
  logic   grant_reg, grant_next;
  logic   winner;
  logic   accept;

  logic [DATA_W-1:0] src1_reg, src2_reg;
  logic [CTRL_W-1:0] ctrl_reg;

  // Per-requester response state, indexed by requester number.
  logic [1:0]        req_valid;
  logic [1:0]        rsp_ready_vec;
  logic              rsp_valid_reg [2];
  logic [DATA_W-1:0] result_reg    [2];
  logic [2:0]        zcv_reg       [2];

  assign req_valid     = {r1_valid, r0_valid};
  assign rsp_ready_vec = {r1_rsp_ready, r0_rsp_ready};

  // Priority only matters when both ask; a lone requester always wins.
  always_comb begin
    winner = 1'b0;
    if (r0_valid && r1_valid) begin
      winner = prio_reg;
    end else if (r1_valid) begin
      winner = 1'b1;
    end
  end

  assign accept = (state_reg == IDLE) && (r0_valid || r1_valid);

  always_comb begin
    state_next = state_reg;
    prio_next  = prio_reg;
    grant_next = grant_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          grant_next = winner;
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready_vec[grant_reg]) begin
          // Hand priority to the other requester once this one is served.
          prio_next  = ~grant_reg;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      prio_reg  <= RR_INIT_BIT;
      grant_reg <= RR_INIT_BIT;
      src1_reg  <= '0;
      src2_reg  <= '0;
      ctrl_reg  <= '0;
    end else begin
      state_reg <= state_next;
      prio_reg  <= prio_next;
      grant_reg <= grant_next;
      // Operands are sampled only on the accept edge; later input changes
      // cannot disturb the operation in flight.
      if (accept) begin
        src1_reg <= winner ? r1_src1 : r0_src1;
        src2_reg <= winner ? r2_sel_src2(r0_src2, r1_src2, winner) : r0_src2;
        ctrl_reg <= winner ? r1_ctrl : r0_ctrl;
      end
    end
  end

  function automatic logic [DATA_W-1:0] r2_sel_src2(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic              sel
  );
    return sel ? b : a;
  endfunction

  // Response capture: only the granted requester's registers move.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rsp_valid_reg[gi] <= 1'b0;
        result_reg[gi]    <= '0;
        zcv_reg[gi]       <= '0;
      end else if (grant_reg == 1'(gi)) begin
        if (state_reg == EXEC) begin
          rsp_valid_reg[gi] <= 1'b1;
          result_reg[gi]    <= alu_result;
          zcv_reg[gi]       <= {alu_zero, alu_cout, alu_overflow};
        end else if (state_reg == RESP && rsp_ready_vec[gi]) begin
          rsp_valid_reg[gi] <= 1'b0;
        end
      end
    end
  end

  assign r0_ready     = (state_reg == IDLE) && req_valid[0] && !winner;
  assign r1_ready     = (state_reg == IDLE) && req_valid[1] &&  winner;

  assign r0_rsp_valid = rsp_valid_reg[0];
  assign r0_result    = result_reg[0];
  assign r0_zcv       = zcv_reg[0];
  assign r1_rsp_valid = rsp_valid_reg[1];
  assign r1_result    = result_reg[1];
  assign r1_zcv       = zcv_reg[1];

  assign alu_rst_n    = ~rst;
  assign alu_src1     = src1_reg;
  assign alu_src2     = src2_reg;
  assign alu_ctrl     = ctrl_reg;

  assign busy         = (state_reg != IDLE);
  assign grant        = grant_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to the
// alu_* ports. Single-requester operations come from a vector table; the
// multi-cycle cases (alternation, back-pressure, reset mid-op, operand
// change after accept) are hand-written sequences.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_valid = 0, r1_valid = 0;
  logic        r0_ready, r1_ready;
  logic [31:0] r0_src1 = 0, r0_src2 = 0, r1_src1 = 0, r1_src2 = 0;
  logic [3:0]  r0_ctrl = 0, r1_ctrl = 0;
  logic        r0_rsp_valid, r1_rsp_valid;
  logic        r0_rsp_ready = 0, r1_rsp_ready = 0;
  logic [31:0] r0_result, r1_result;
  logic [2:0]  r0_zcv, r1_zcv;
  logic        alu_rst_n;
  logic [31:0] alu_src1, alu_src2;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero, alu_cout, alu_overflow;
  logic        busy, grant;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(32), .CTRL_W(4), .RR_INIT(0)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_src1(r0_src1),
    .r0_src2(r0_src2), .r0_ctrl(r0_ctrl), .r0_rsp_valid(r0_rsp_valid),
    .r0_rsp_ready(r0_rsp_ready), .r0_result(r0_result), .r0_zcv(r0_zcv),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_src1(r1_src1),
    .r1_src2(r1_src2), .r1_ctrl(r1_ctrl), .r1_rsp_valid(r1_rsp_valid),
    .r1_rsp_ready(r1_rsp_ready), .r1_result(r1_result), .r1_zcv(r1_zcv),
    .alu_rst_n(alu_rst_n), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_cout(alu_cout), .alu_overflow(alu_overflow),
    .busy(busy), .grant(grant)
  );

  // Behavioural ALU: and/or/add/sub; any other code yields zero.
  logic [32:0] alu_wide;
  always_comb begin
    alu_wide     = 33'd0;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      4'b0000: alu_wide = {1'b0, alu_src1 & alu_src2};
      4'b0001: alu_wide = {1'b0, alu_src1 | alu_src2};
      4'b0010: begin
        alu_wide     = {1'b0, alu_src1} + {1'b0, alu_src2};
        alu_overflow = (alu_src1[31] == alu_src2[31]) && (alu_wide[31] != alu_src1[31]);
      end
      4'b0110: begin
        alu_wide     = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;
        alu_overflow = (alu_src1[31] != alu_src2[31]) && (alu_wide[31] != alu_src1[31]);
      end
      default: alu_wide = 33'd0;
    endcase
    alu_result = alu_wide[31:0];
    alu_cout   = alu_wide[32];
    alu_zero   = (alu_wide[31:0] == 32'd0);
  end

  typedef struct {
    logic        req;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [3:0]  ctrl;
    logic [31:0] exp_r;
    logic [2:0]  exp_zcv;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    r0_valid = 0; r1_valid = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete single-requester operation with full-speed response.
  task automatic run_op(input vec_t v);
    @(negedge clk);
    if (v.req) begin
      r1_valid = 1; r1_src1 = v.s1; r1_src2 = v.s2; r1_ctrl = v.ctrl;
      r1_rsp_ready = 1; r0_rsp_ready = 0;
    end else begin
      r0_valid = 1; r0_src1 = v.s1; r0_src2 = v.s2; r0_ctrl = v.ctrl;
      r0_rsp_ready = 1; r1_rsp_ready = 0;
    end
    #1;
    check("winner_ready", v.req ? r1_ready : r0_ready, 1);
    check("loser_ready",  v.req ? r0_ready : r1_ready, 0);
    @(negedge clk);
    r0_valid = 0; r1_valid = 0;
    check("exec_busy", busy, 1);
    check("exec_alu_src1", alu_src1, v.s1);
    check("exec_alu_src2", alu_src2, v.s2);
    check("exec_alu_ctrl", alu_ctrl, v.ctrl);
    check("exec_no_rsp", v.req ? r1_rsp_valid : r0_rsp_valid, 0);
    @(negedge clk);
    check("rsp_valid", v.req ? r1_rsp_valid : r0_rsp_valid, 1);
    check("rsp_result", v.req ? r1_result : r0_result, v.exp_r);
    check("rsp_zcv", v.req ? r1_zcv : r0_zcv, v.exp_zcv);
    check("rsp_grant", grant, v.req);
    @(negedge clk);
    check("done_busy", busy, 0);
    check("done_rsp_valid", v.req ? r1_rsp_valid : r0_rsp_valid, 0);
    $display("op r%0d ctrl=%b %h,%h -> %h zcv=%b", v.req, v.ctrl, v.s1, v.s2,
             v.req ? r1_result : r0_result, v.req ? r1_zcv : r0_zcv);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0005, 32'h0000_0003, 4'b0010, 32'h0000_0008, 3'b000};
    vecs[1] = '{1'b1, 32'h0000_0007, 32'h0000_0007, 4'b0110, 32'h0000_0000, 3'b110};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0010, 32'h0000_0000, 3'b110};
    vecs[3] = '{1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 32'h8000_0000, 3'b001};
    vecs[4] = '{1'b0, 32'h0000_0003, 32'h0000_0005, 4'b0110, 32'hFFFF_FFFE, 3'b000};
    vecs[5] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 4'b0110, 32'h7FFF_FFFF, 3'b011};
    vecs[6] = '{1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0000, 32'h00F0_00F0, 3'b000};
    vecs[7] = '{1'b1, 32'h1234_5678, 32'h0000_0001, 4'b1111, 32'h0000_0000, 3'b100};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_alu_rst_n", alu_rst_n, 0);
    check("rst_alu_src1", alu_src1, 0);
    check("rst_alu_ctrl", alu_ctrl, 0);
    check("rst_r0_rsp_valid", r0_rsp_valid, 0);
    check("rst_r1_result", r1_result, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("run_alu_rst_n", alu_rst_n, 1);

    // Table: lone requester, starting with r1 while prio is still r0.
    run_op(vecs[1]);
    for (int i = 0; i < 8; i++) run_op(vecs[i]);

    // Both continuously valid: grants alternate r0, r1, r0, r1.
    do_reset();
    @(negedge clk);
    r0_valid = 1; r0_src1 = 32'd7; r0_src2 = 32'd7; r0_ctrl = 4'b0110;
    r1_valid = 1; r1_src1 = 32'hFFFF_FFFF; r1_src2 = 32'd1; r1_ctrl = 4'b0010;
    r0_rsp_ready = 1; r1_rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_r0_ready", r0_ready, (k % 2) == 0);
      check("rr_r1_ready", r1_ready, (k % 2) == 1);
      @(negedge clk);
      check("rr_grant", grant, k % 2);
      @(negedge clk);
      check("rr_rsp_valid", (k % 2) ? r1_rsp_valid : r0_rsp_valid, 1);
      check("rr_other_rsp", (k % 2) ? r0_rsp_valid : r1_rsp_valid, 0);
      check("rr_result", (k % 2) ? r1_result : r0_result, 32'h0);
      check("rr_zcv", (k % 2) ? r1_zcv : r0_zcv, 3'b110);
      $display("rr op %0d granted r%0d", k, grant);
      @(negedge clk);
    end
    r0_valid = 0; r1_valid = 0;

    // Back-pressure on r1 while r0 waits.
    @(negedge clk);
    r1_valid = 1; r1_src1 = 32'h7FFF_FFFF; r1_src2 = 32'd1; r1_ctrl = 4'b0010;
    r1_rsp_ready = 0; r0_rsp_ready = 0;
    #1;
    check("bp_r1_ready", r1_ready, 1);
    @(negedge clk);
    r1_valid = 0;
    r0_valid = 1; r0_src1 = 32'd5; r0_src2 = 32'd3; r0_ctrl = 4'b0010;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", r1_rsp_valid, 1);
      check("bp_result", r1_result, 32'h8000_0000);
      check("bp_zcv", r1_zcv, 3'b001);
      check("bp_r0_ready", r0_ready, 0);
      check("bp_grant", grant, 1);
      @(negedge clk);
    end
    r1_rsp_ready = 1;
    @(negedge clk);
    check("bp_released", r1_rsp_valid, 0);
    check("bp_result_kept", r1_result, 32'h8000_0000);
    #1;
    check("bp_r0_now_ready", r0_ready, 1);
    r0_rsp_ready = 1;
    @(negedge clk);
    r0_valid = 0;
    @(negedge clk);
    check("bp_r0_result", r0_result, 32'h8);
    $display("bp r1 held 5 cycles, then r0 -> %h", r0_result);
    @(negedge clk);

    // Reset during EXEC; prio was left at r1 beforehand.
    do_reset();
    run_op(vecs[0]);
    @(negedge clk);
    r1_valid = 1; r1_src1 = 32'd9; r1_src2 = 32'd2; r1_ctrl = 4'b0110;
    r1_rsp_ready = 1;
    #1;
    check("mid_r1_ready", r1_ready, 1);
    @(negedge clk);
    r1_valid = 0;
    #2 rst = 1'b1;
    #1;
    check("mid_busy", busy, 0);
    check("mid_alu_src1", alu_src1, 0);
    check("mid_alu_src2", alu_src2, 0);
    check("mid_alu_ctrl", alu_ctrl, 0);
    check("mid_grant", grant, 0);
    check("mid_alu_rst_n", alu_rst_n, 0);
    check("mid_r0_result", r0_result, 0);
    check("mid_r0_zcv", r0_zcv, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("mid_no_rsp", r1_rsp_valid, 0);
      @(negedge clk);
    end
    r0_valid = 1; r0_src1 = 32'd1; r0_src2 = 32'd2; r0_ctrl = 4'b0010;
    r1_valid = 1;
    r0_rsp_ready = 1;
    #1;
    check("post_rst_r0_ready", r0_ready, 1);
    check("post_rst_r1_ready", r1_ready, 0);
    @(negedge clk);
    r0_valid = 0; r1_valid = 0;
    @(negedge clk);
    check("post_rst_result", r0_result, 32'd3);
    $display("reset mid-op dropped, next grant r%0d -> %h", grant, r0_result);
    @(negedge clk);

    // Operand change after accept does not affect the operation.
    @(negedge clk);
    r0_valid = 1; r0_src1 = 32'd10; r0_src2 = 32'd4; r0_ctrl = 4'b0110;
    r0_rsp_ready = 1;
    #1;
    check("chg_ready", r0_ready, 1);
    @(negedge clk);
    r0_valid = 0; r0_src1 = 32'd100; r0_src2 = 32'd1; r0_ctrl = 4'b0010;
    @(negedge clk);
    check("chg_result", r0_result, 32'd6);
    check("chg_zcv", r0_zcv, 3'b010);
    $display("operand change after accept -> %h zcv=%b", r0_result, r0_zcv);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational 32-bit ALU between two requesters, r0 and r1, using round-robin arbitration.
- Each requester issues one operation with a valid/ready handshake: src1, src2 and the 4-bit ALU_control code.
- The block registers the operands, drives them into the ALU, captures the result and the {zero,cout,overflow} flags, and returns them over a per-requester response handshake.
- It sits between the execute-stage issuers and the alu instance. The alu's active-low rst_n is driven from this block.

Parameters:
- DATA_W, 32, operand and result width.
- CTRL_W, 4, ALU_control width.
- RR_INIT, 0, requester holding priority after reset (0 or 1).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-high.
- r0_valid  in  1  requester 0 has an operation.
- r0_ready  out  1  requester 0 operation accepted this cycle.
- r0_src1  in  DATA_W  requester 0 operand 1.
- r0_src2  in  DATA_W  requester 0 operand 2.
- r0_ctrl  in  CTRL_W  requester 0 ALU_control.
- r0_rsp_valid  out  1  requester 0 response available.
- r0_rsp_ready  in  1  requester 0 takes the response.
- r0_result  out  DATA_W  requester 0 result.
- r0_zcv  out  3  requester 0 flags {zero,cout,overflow}.
- r1_*  same set as r0_*, for requester 1.
- alu_rst_n  out  1  ALU reset; equals ~rst.
- alu_src1  out  DATA_W  registered ALU operand 1.
- alu_src2  out  DATA_W  registered ALU operand 2.
- alu_ctrl  out  CTRL_W  registered ALU_control.
- alu_result  in  DATA_W  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_cout  in  1  ALU carry-out flag.
- alu_overflow  in  1  ALU overflow flag.
- busy  out  1  high whenever state != IDLE.
- grant  out  1  requester currently owning the ALU.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, prio=RR_INIT, grant=RR_INIT.
  - alu_src1/alu_src2/alu_ctrl=0.
  - r*_rsp_valid=0, r*_result=0, r*_zcv=0.
  - busy=0. rN_ready is 0 in all states except IDLE.
- IDLE:
  - Winner selection: if both valid, winner=prio; if only one valid, winner is that one.
  - rN_ready=1 combinationally for the winner only; the loser's ready stays 0.
  - On the edge: latch the winner's src1/src2/ctrl into alu_*, set grant=winner, go to EXEC.
  - If neither requester is valid, stay in IDLE.
- EXEC (one cycle):
  - The ALU settles on the registered inputs.
  - On the edge: copy alu_result into r[grant]_result and {alu_zero,alu_cout,alu_overflow} into r[grant]_zcv.
  - Set r[grant]_rsp_valid=1 and go to RESP.
- RESP:
  - Hold rsp_valid, result and zcv stable until r[grant]_rsp_ready=1.
  - On the edge where rsp_ready=1: clear rsp_valid, set prio=~grant, go to IDLE.
  - rsp_ready may already be high when rsp_valid rises; the handshake then completes on the first RESP edge.
- Latency: accept edge N -> alu_* valid from N+1 -> rsp_valid from N+2.
  - Best-case throughput is 1 operation per 3 cycles (accept, exec, resp). There is no accept in the same cycle a response completes.
- Input rules:
  - Requesters hold src/ctrl stable while valid=1 and ready=0.
  - The block samples inputs only on the accept edge. Changes afterwards have no effect on the in-flight operation.
- Non-granted requester's outputs: rsp_valid=0; result/zcv keep their last values.
- Fairness: with both requesters continuously valid, grants alternate r0, r1, r0, … starting from RR_INIT. Neither requester waits more than one operation.
- Width: no extension or truncation. The result and flags pass through exactly as the ALU produces them.
- Reset mid-operation (EXEC or RESP): the operation is dropped with no response. All state returns to reset values. The requester must reissue.
- Unknown ctrl codes are forwarded unchanged; the response carries whatever the ALU outputs.

Test Plan:
- Reset, then r0 issues add (ctrl 0010), src1=0x00000005, src2=0x00000003, with rsp_ready=1 -> r0_ready high for 1 cycle; r0_rsp_valid 2 cycles after accept; result=0x00000008, zcv=000; busy low one cycle later.
- Both requesters valid every cycle, RR_INIT=0: r0 sub (0110) 7-7 and r1 add 0xFFFFFFFF+1 -> grant order r0, r1, r0, r1. r0 gets 0x00000000 with zcv=110; r1 gets 0x00000000 with zcv=110.
- r1 add 0x7FFFFFFF+1 with rsp_ready held low 5 cycles -> r1_rsp_valid stays high; result=0x80000000, zcv=001, stable throughout. No new grant occurs until rsp_ready rises.
- Only r1 valid while prio=0 -> r1 is granted immediately; r0_ready stays 0.
- Assert rst during EXEC -> all outputs return to reset values asynchronously; no rsp_valid is ever produced for that operation; the next request is granted to RR_INIT.
- r0 changes src1 after its accept edge -> the response reflects the operands sampled at accept.
